// File: rtl/wm8731_cfg_seq.sv
// WM8731 control-port configuration sequencer: plays the codec init table through an
// I2C write engine, then serves single user register writes with NACK retry and timeout.
module wm8731_cfg_seq #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 16,
  parameter int         TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        usr_req,
  input  logic [6:0]  usr_reg,
  input  logic [8:0]  usr_data,
  output logic        usr_ack,
  output logic        usr_nack,
  output logic        i2c_go,
  output logic [23:0] i2c_word,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        init_done,
  output logic        err
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    TBL_LEN  = 4'd11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE_CHK} state_t;

  state_t        state, state_n;
  logic [3:0]    idx;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic          mode_usr;
  logic          again;
  logic          done_ok;
  logic          fail;

  // Init table entries packed as {reg[6:0], data[8:0]}
  function automatic logic [15:0] table_entry(input logic [3:0] i);
    case (i)
      4'd0:    table_entry = {7'h0F, 9'h000};
      4'd1:    table_entry = {7'h00, 9'h017};
      4'd2:    table_entry = {7'h01, 9'h017};
      4'd3:    table_entry = {7'h02, 9'h079};
      4'd4:    table_entry = {7'h03, 9'h079};
      4'd5:    table_entry = {7'h04, 9'h012};
      4'd6:    table_entry = {7'h05, 9'h000};
      4'd7:    table_entry = {7'h06, 9'h000};
      4'd8:    table_entry = {7'h07, 9'h00A};
      4'd9:    table_entry = {7'h08, 9'h000};
      4'd10:   table_entry = {7'h09, 9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  function automatic logic [23:0] make_word(input logic [15:0] e);
    make_word = {DEV_ADDR, 1'b0, e};
  endfunction

  // A done with ACK wins over a timeout expiring in the same cycle
  assign done_ok = i2c_done && !i2c_nack;
  assign fail    = !done_ok && ((i2c_done && i2c_nack) || (timer == TO_LAST));
  assign busy    = (state != IDLE);

  always_comb begin
    state_n = state;
    i2c_go  = 1'b0;
    case (state)
      IDLE: begin
        if (start || (usr_req && init_done)) state_n = ISSUE;
      end
      ISSUE: begin
        if (!i2c_busy) begin
          i2c_go  = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (done_ok || fail) state_n = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = DONE_CHK;
      end
      DONE_CHK: begin
        if (again || (!mode_usr && !err && idx != TBL_LEN)) state_n = ISSUE;
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      retry     <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      mode_usr  <= 1'b0;
      again     <= 1'b0;
      i2c_word  <= '0;
      usr_ack   <= 1'b0;
      usr_nack  <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_n;
      usr_ack  <= 1'b0;
      usr_nack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err       <= 1'b0;
            init_done <= 1'b0;
            mode_usr  <= 1'b0;
            idx       <= '0;
            retry     <= '0;
            again     <= 1'b0;
            i2c_word  <= make_word(table_entry(4'd0));
          end else if (usr_req && init_done) begin
            mode_usr <= 1'b1;
            retry    <= '0;
            again    <= 1'b0;
            i2c_word <= make_word({usr_reg, usr_data});
          end
        end
        ISSUE: begin
          if (!i2c_busy) timer <= '0;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (done_ok) begin
            gap_cnt <= '0;
            again   <= 1'b0;
            if (mode_usr) usr_ack <= 1'b1;
            else begin
              idx   <= idx + 1'b1;
              retry <= '0;
            end
          end else if (fail) begin
            gap_cnt <= '0;
            if (retry < MAX_R) begin
              retry <= retry + 1'b1;
              again <= 1'b1;
            end else begin
              again <= 1'b0;
              if (mode_usr) begin
                usr_ack  <= 1'b1;
                usr_nack <= 1'b1;
              end else err <= 1'b1;
            end
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        DONE_CHK: begin
          if (!again && !mode_usr && !err && idx == TBL_LEN) init_done <= 1'b1;
          // User words stay latched in i2c_word; only the table path reloads
          if (state_n == ISSUE && !mode_usr) i2c_word <= make_word(table_entry(idx));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Directed bench for wm8731_cfg_seq with a behavioural I2C engine that ACKs after
// 50 clocks, can NACK a chosen word a set number of times, or stay silent.
module tb_wm8731_cfg_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        usr_req = 1'b0;
  logic [6:0]  usr_reg = '0;
  logic [8:0]  usr_data = '0;
  logic        usr_ack, usr_nack, i2c_go, busy, init_done, err;
  logic [23:0] i2c_word;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;

  wm8731_cfg_seq dut (
    .clk(clk), .reset(reset), .start(start), .usr_req(usr_req), .usr_reg(usr_reg),
    .usr_data(usr_data), .usr_ack(usr_ack), .usr_nack(usr_nack), .i2c_go(i2c_go),
    .i2c_word(i2c_word), .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .busy(busy), .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic        mute = 1'b0;
  logic [23:0] nack_word = '0;
  int          nack_limit = 0;
  int          nack_seen = 0;
  int          done_edge [64];
  int          done_cnt = 0;
  logic [23:0] eng_word;

  // Engine: busy after the go edge, done sampled 50 edges after it
  always begin
    @(negedge clk);
    if (i2c_go && !mute) begin
      eng_word = i2c_word;
      @(posedge clk); #1 i2c_busy = 1'b1;
      repeat (49) @(posedge clk);
      #1 i2c_done = 1'b1;
      i2c_nack = (eng_word == nack_word) && (nack_seen < nack_limit);
      if (i2c_nack) nack_seen++;
      if (done_cnt < 64) done_edge[done_cnt] = cyc + 1;
      done_cnt++;
      @(posedge clk); #1 i2c_done = 1'b0;
      i2c_nack = 1'b0;
      i2c_busy = 1'b0;
    end
  end

  logic [23:0] go_word [64];
  int          go_cyc [64];
  logic        go_ido [64];
  int          go_cnt = 0;
  int          ack_cnt = 0;

  always @(negedge clk) begin
    if (i2c_go) begin
      if (go_cnt < 64) begin
        go_word[go_cnt] = i2c_word;
        go_cyc[go_cnt]  = cyc;
        go_ido[go_cnt]  = init_done;
      end
      go_cnt++;
    end
    if (usr_ack) ack_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic u, input logic [6:0] r, input logic [8:0] d);
    @(negedge clk);
    start = s; usr_req = u; usr_reg = r; usr_data = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    checkOutput(tag, busy, 1'b0);
  endtask

  task automatic waitAck(input int budget, input string tag);
    int n = 0;
    while (!usr_ack && n < budget) begin @(negedge clk); n++; end
    checkOutput(tag, usr_ack, 1'b1);
  endtask

  logic [23:0] exp_tbl [11];
  int b, db, a, mg, g;

  initial begin
    exp_tbl = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
                24'h340A00, 24'h340C00, 24'h340E0A, 24'h341000, 24'h341201};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_go", i2c_go, 1'b0);
    checkOutput("rst_word", i2c_word, 24'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_flags", {err, init_done, usr_ack, usr_nack}, 4'b0);

    // Clean init run
    b = go_cnt; db = done_cnt;
    applyStimulus(1'b1, 1'b0, 7'h0, 9'h0);
    checkOutput("t1_go_latency", i2c_go, 1'b1);
    checkOutput("t1_first_word", i2c_word, 24'h341E00);
    waitIdle(2000, "t1_idle");
    checkOutput("t1_count", go_cnt - b, 11);
    for (int k = 0; k < 11; k++) checkOutput($sformatf("t1_word%0d", k), go_word[b+k], exp_tbl[k]);
    checkOutput("t1_init_done", init_done, 1'b1);
    checkOutput("t1_err", err, 1'b0);
    checkOutput("t1_done_latency", cyc - done_edge[done_cnt-1], 17);
    mg = 1000000;
    for (int k = 1; k < 11; k++) begin
      g = go_cyc[b+k] - done_edge[db+k-1];
      if (g < mg) mg = g;
    end
    checkOutput("t1_min_gap", mg >= 16, 1'b1);

    // Two NACKs on entry 2, then ACK
    nack_word = 24'h340479; nack_limit = nack_seen + 2;
    b = go_cnt;
    applyStimulus(1'b1, 1'b0, 7'h0, 9'h0);
    waitIdle(3000, "t2_idle");
    checkOutput("t2_count", go_cnt - b, 13);
    for (int k = 3; k < 6; k++) checkOutput($sformatf("t2_repeat%0d", k), go_word[b+k], 24'h340479);
    checkOutput("t2_next", go_word[b+6], 24'h340679);
    checkOutput("t2_flags", {init_done, err}, 2'b10);

    // Four NACKs on entry 4 abort the init
    nack_word = 24'h340812; nack_limit = nack_seen + 4;
    b = go_cnt;
    applyStimulus(1'b1, 1'b0, 7'h0, 9'h0);
    waitIdle(3000, "t3_idle");
    checkOutput("t3_count", go_cnt - b, 9);
    checkOutput("t3_first_try", go_word[b+5], 24'h340812);
    checkOutput("t3_last_try", go_word[b+8], 24'h340812);
    checkOutput("t3_flags", {err, init_done, busy}, 3'b100);
    repeat (100) @(negedge clk);
    checkOutput("t3_no_more_go", go_cnt - b, 9);
    b = go_cnt;
    applyStimulus(1'b1, 1'b0, 7'h0, 9'h0);
    checkOutput("t3_err_cleared", err, 1'b0);
    checkOutput("t3_restart_word", i2c_word, 24'h341E00);
    waitIdle(2000, "t3_reinit_idle");
    checkOutput("t3_reinit_done", init_done, 1'b1);

    // User writes after init
    b = go_cnt; a = ack_cnt;
    applyStimulus(1'b0, 1'b1, 7'h02, 9'h07F);
    waitAck(500, "t4_ack");
    checkOutput("t4_nack", usr_nack, 1'b0);
    usr_req = 1'b0;
    waitIdle(200, "t4_idle");
    checkOutput("t4_word", go_word[b], 24'h34047F);
    checkOutput("t4_count", go_cnt - b, 1);
    checkOutput("t4_ack_count", ack_cnt - a, 1);
    nack_word = 24'h3409AB; nack_limit = nack_seen + 4;
    b = go_cnt; a = ack_cnt;
    applyStimulus(1'b0, 1'b1, 7'h04, 9'h1AB);
    waitAck(2000, "t4_fail_ack");
    checkOutput("t4_fail_nack", usr_nack, 1'b1);
    usr_req = 1'b0;
    waitIdle(200, "t4_fail_idle");
    checkOutput("t4_fail_count", go_cnt - b, 4);
    checkOutput("t4_fail_word", go_word[b+3], 24'h3409AB);
    checkOutput("t4_fail_ack_count", ack_cnt - a, 1);

    // start and usr_req together from a fresh reset
    applyReset();
    checkOutput("t5_init_cleared", init_done, 1'b0);
    b = go_cnt; a = ack_cnt;
    applyStimulus(1'b1, 1'b1, 7'h05, 9'h006);
    checkOutput("t5_start_first", i2c_word, 24'h341E00);
    waitAck(3000, "t5_ack");
    usr_req = 1'b0;
    waitIdle(200, "t5_idle");
    checkOutput("t5_count", go_cnt - b, 12);
    checkOutput("t5_last_init", go_word[b+10], 24'h341201);
    checkOutput("t5_user_word", go_word[b+11], 24'h340A06);
    checkOutput("t5_after_init", go_ido[b+11], 1'b1);
    checkOutput("t5_ack_count", ack_cnt - a, 1);

    // Silent engine: timeouts, then reset during WAIT
    applyReset();
    mute = 1'b1;
    b = go_cnt;
    applyStimulus(1'b1, 1'b0, 7'h0, 9'h0);
    waitIdle(17500, "t6_idle");
    checkOutput("t6_count", go_cnt - b, 4);
    checkOutput("t6_retry_spacing", go_cyc[b+1] - go_cyc[b], 4114);
    checkOutput("t6_retry_word", go_word[b+3], 24'h341E00);
    checkOutput("t6_err", {err, init_done}, 2'b10);
    b = go_cnt;
    applyStimulus(1'b1, 1'b0, 7'h0, 9'h0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_outputs", {i2c_go, busy, err, init_done, usr_ack, usr_nack}, 6'b0);
    checkOutput("t6_rst_word", i2c_word, 24'h0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("t6_no_go_after_rst", go_cnt - b, 1);
    mute = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
